// File: rtl/blinkspeed_decoder_if.sv
// Bus between an RGB blink-speed sequencer (master) and its decoder/checker (slave).
// The LED pattern flows to the decoder, and the recovered speed and status flow back.
interface blinkspeed_decoder_if;
    logic [2:0] LED_IN;
    logic [1:0] SPEED;
    logic       VALID;
    logic       SEQERR;
    logic       STALL;

    modport master (
        output LED_IN,
        input  SPEED,
        input  VALID,
        input  SEQERR,
        input  STALL
    );

    modport slave (
        input  LED_IN,
        output SPEED,
        output VALID,
        output SEQERR,
        output STALL
    );
endinterface

// File: rtl/blinkspeed_decoder.sv
// Recovers the 2-bit speed code from an observed 5-step RGB blink cycle.
// It also checks step order and flags a pattern that stops changing.
module blinkspeed_decoder #(
    parameter int BASE_LOG2 = 24,
    parameter int TOL_SHIFT = 3,
    parameter int LOCK_CNT  = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    blinkspeed_decoder_if.slave  bus
);

    localparam int W = BASE_LOG2 + 4;
    localparam logic [W-1:0] DWELL_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] DWELL_MAX  = {W{1'b1}};
    localparam logic [W-1:0] TIMEOUT    = (DWELL_ONE << (BASE_LOG2 + 3)) |
                                          (DWELL_ONE << (BASE_LOG2 + 2));
    localparam logic [2:0]   MATCH_LOCK = 3'(LOCK_CNT);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   s1_q, s1_d;
    logic [2:0]   s2_q, s2_d;
    logic [2:0]   prev_q, prev_d;
    logic [W-1:0] dwell_q, dwell_d;
    logic [1:0]   cand_q, cand_d;
    logic [2:0]   match_q, match_d;
    logic [1:0]   speed_q, speed_d;
    logic         valid_q, valid_d;
    logic         seqerr_q, seqerr_d;
    logic         stall_q, stall_d;

    logic         change;
    logic         legal;
    logic [2:0]   cls;
    logic         cls_hit;
    logic [1:0]   cls_code;

    function automatic logic is_legal(input logic [2:0] from_pat, input logic [2:0] to_pat);
        logic ok;
        ok = 1'b0;
        case ({from_pat, to_pat})
            6'b100_010,
            6'b010_001,
            6'b001_111,
            6'b111_000,
            6'b000_100: ok = 1'b1;
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Windows are disjoint while TOL_SHIFT >= 2, so at most one code can hit.
    function automatic logic [2:0] classify(input logic [W-1:0] d);
        logic [2:0]   r;
        logic [W-1:0] nom;
        logic [W-1:0] tol;
        r = 3'b000;
        for (int k = 0; k < 4; k++) begin
            nom = DWELL_ONE << (BASE_LOG2 + 3 - k);
            tol = nom >> TOL_SHIFT;
            if ((d >= nom - tol) && (d <= nom + tol)) begin
                r = {1'b1, k[1:0]};
            end
        end
        return r;
    endfunction

    assign change   = (s2_q != prev_q);
    assign legal    = is_legal(prev_q, s2_q);
    assign cls      = classify(dwell_q);
    assign cls_hit  = cls[2];
    assign cls_code = cls[1:0];

    always_comb begin
        s1_d     = bus.LED_IN;
        s2_d     = s1_q;
        prev_d   = s2_q;
        state_d  = state_q;
        cand_d   = cand_q;
        match_d  = match_q;
        speed_d  = speed_q;
        valid_d  = valid_q;
        seqerr_d = 1'b0;
        stall_d  = stall_q;

        if (change) begin
            dwell_d = DWELL_ONE;
        end else if (dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + DWELL_ONE;
        end else begin
            dwell_d = dwell_q;
        end

        // At a change, dwell_q still holds the full dwell of the outgoing pattern.
        if (change) begin
            case (state_q)
                HUNT: begin
                    stall_d = 1'b0;
                    match_d = 3'd0;
                    state_d = MEASURE;
                end
                MEASURE: begin
                    if (!legal) begin
                        seqerr_d = 1'b1;
                        match_d  = 3'd0;
                    end else if (!cls_hit) begin
                        match_d = 3'd0;
                    end else begin
                        if ((cls_code == cand_q) && (match_q != 3'd0)) begin
                            match_d = match_q + 3'd1;
                        end else begin
                            cand_d  = cls_code;
                            match_d = 3'd1;
                        end
                        if (match_d == MATCH_LOCK) begin
                            state_d = LOCKED;
                            speed_d = cand_d;
                            valid_d = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        seqerr_d = 1'b1;
                        valid_d  = 1'b0;
                        match_d  = 3'd0;
                        state_d  = MEASURE;
                    end else if (!cls_hit) begin
                        valid_d = 1'b0;
                        match_d = 3'd0;
                        state_d = MEASURE;
                    end else if (cls_code != cand_q) begin
                        valid_d = 1'b0;
                        cand_d  = cls_code;
                        match_d = 3'd1;
                        state_d = MEASURE;
                    end
                end
                default: begin
                    match_d = 3'd0;
                    valid_d = 1'b0;
                    state_d = HUNT;
                end
            endcase
        end else if (dwell_q == TIMEOUT) begin
            stall_d = 1'b1;
            valid_d = 1'b0;
            match_d = 3'd0;
            state_d = HUNT;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_q     <= 3'b000;
            s2_q     <= 3'b000;
            prev_q   <= 3'b000;
            dwell_q  <= '0;
            state_q  <= HUNT;
            cand_q   <= 2'd0;
            match_q  <= 3'd0;
            speed_q  <= 2'd0;
            valid_q  <= 1'b0;
            seqerr_q <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            prev_q   <= prev_d;
            dwell_q  <= dwell_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            speed_q  <= speed_d;
            valid_q  <= valid_d;
            seqerr_q <= seqerr_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.SPEED  = speed_q;
    assign bus.VALID  = valid_q;
    assign bus.SEQERR = seqerr_q;
    assign bus.STALL  = stall_q;

endmodule

// File: tb/tb_blinkspeed_decoder.sv
// Self-checking bench for blinkspeed_decoder using a pattern-level reference model.
// Expected outputs are queued when each LED step is driven and compared once the DUT responds.
module tb_blinkspeed_decoder;

    localparam int BASE_LOG2 = 4;
    localparam int TOL_SHIFT = 3;
    localparam int LOCK_CNT  = 2;
    localparam int TO        = 192;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    blinkspeed_decoder_if bus ();

    blinkspeed_decoder #(
        .BASE_LOG2 (BASE_LOG2),
        .TOL_SHIFT (TOL_SHIFT),
        .LOCK_CNT  (LOCK_CNT)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    typedef struct packed {
        logic       valid;
        logic [1:0] speed;
        logic       seqerr;
        logic       stall;
    } exp_t;

    typedef enum int {M_HUNT, M_MEASURE, M_LOCKED} mstate_t;

    int      checks   = 0;
    int      failures = 0;
    exp_t    expQ[$];
    string   tagQ[$];

    mstate_t    mState;
    int         mCand;
    int         mMatch;
    logic [1:0] mSpeed;
    logic       mValid;
    logic       mSeqerr;
    logic       mStall;
    logic [2:0] prevPat;
    int         prevDwell;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    // Nominal windows for the bench parameters: N0=128, N1=64, N2=32, N3=16, each +/- N/8.
    function automatic int classifyRef(input int d);
        if (d >= 112 && d <= 144) return 0;
        if (d >= 56 && d <= 72)   return 1;
        if (d >= 28 && d <= 36)   return 2;
        if (d >= 14 && d <= 18)   return 3;
        return -1;
    endfunction

    function automatic bit legalRef(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] cyc [5];
        bit ok;
        cyc[0] = 3'b100;
        cyc[1] = 3'b010;
        cyc[2] = 3'b001;
        cyc[3] = 3'b111;
        cyc[4] = 3'b000;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (a == cyc[i] && b == cyc[(i + 1) % 5]) ok = 1'b1;
        end
        return ok;
    endfunction

    task automatic modelReset();
        mState    = M_HUNT;
        mCand     = 0;
        mMatch    = 0;
        mSpeed    = 2'd0;
        mValid    = 1'b0;
        mSeqerr   = 1'b0;
        mStall    = 1'b0;
        prevPat   = 3'b000;
        prevDwell = 0;
        expQ.delete();
        tagQ.delete();
    endtask

    task automatic pushExpect(input string tag);
        exp_t e;
        e.valid  = mValid;
        e.speed  = mSpeed;
        e.seqerr = mSeqerr;
        e.stall  = mStall;
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic modelChange(input logic [2:0] newPat, input string tag);
        bit legal;
        int code;
        legal   = legalRef(prevPat, newPat);
        code    = classifyRef(prevDwell);
        mSeqerr = 1'b0;
        case (mState)
            M_HUNT: begin
                mStall = 1'b0;
                mMatch = 0;
                mState = M_MEASURE;
            end
            M_MEASURE: begin
                if (!legal) begin
                    mSeqerr = 1'b1;
                    mMatch  = 0;
                end else if (code < 0) begin
                    mMatch = 0;
                end else begin
                    if (code == mCand && mMatch > 0) begin
                        mMatch++;
                    end else begin
                        mCand  = code;
                        mMatch = 1;
                    end
                    if (mMatch == LOCK_CNT) begin
                        mState = M_LOCKED;
                        mSpeed = 2'(mCand);
                        mValid = 1'b1;
                    end
                end
            end
            default: begin
                if (!legal) begin
                    mSeqerr = 1'b1;
                    mValid  = 1'b0;
                    mMatch  = 0;
                    mState  = M_MEASURE;
                end else if (code < 0) begin
                    mValid = 1'b0;
                    mMatch = 0;
                    mState = M_MEASURE;
                end else if (code != int'(mSpeed)) begin
                    mValid = 1'b0;
                    mCand  = code;
                    mMatch = 1;
                    mState = M_MEASURE;
                end
            end
        endcase
        pushExpect(tag);
    endtask

    task automatic popAndCompare(input string where);
        exp_t  e;
        string t;
        checkOutput({where, "/sb_nonempty"}, {31'd0, expQ.size() > 0}, 32'd1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkOutput(t, {27'd0, bus.VALID, bus.SPEED, bus.SEQERR, bus.STALL}, {27'd0, e});
        end
    endtask

    // Called on a falling edge; holds the pattern for exactly `dwell` rising edges.
    task automatic applyStimulus(input logic [2:0] pat, input int dwell, input string tag);
        bit   willTimeout;
        logic preStall;
        bus.LED_IN = pat;
        modelChange(pat, tag);
        preStall    = mStall;
        willTimeout = (dwell >= TO + 3);
        prevPat     = pat;
        for (int c = 0; c < dwell; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) popAndCompare(tag);
            if (c == 3) checkOutput({tag, "/seqerr_one_cycle"}, {31'd0, bus.SEQERR}, 32'd0);
            if (willTimeout && c == TO + 1) begin
                checkOutput({tag, "/stall_before_timeout"}, {31'd0, bus.STALL}, {31'd0, preStall});
            end
            if (willTimeout && c == TO + 2) begin
                mStall  = 1'b1;
                mValid  = 1'b0;
                mMatch  = 0;
                mSeqerr = 1'b0;
                mState  = M_HUNT;
                pushExpect({tag, "/timeout"});
                popAndCompare({tag, "/timeout"});
            end
            @(negedge clk);
        end
        prevDwell = dwell;
    endtask

    task automatic runScenario1(input string pfx);
        applyStimulus(3'b100, 16, {pfx, "_hunt_to_measure"});
        applyStimulus(3'b010, 16, {pfx, "_match1"});
        applyStimulus(3'b001, 16, {pfx, "_lock3"});
        applyStimulus(3'b111, 16, {pfx, "_hold_a"});
        applyStimulus(3'b000, 16, {pfx, "_hold_b"});
        applyStimulus(3'b100, 16, {pfx, "_hold_c"});
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.LED_IN = 3'b000;
        modelReset();
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_async_outputs", {27'd0, bus.VALID, bus.SPEED, bus.SEQERR, bus.STALL}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        runScenario1("s1");

        applyStimulus(3'b010, 32, "s2_last16_stay");
        applyStimulus(3'b001, 32, "s2_first32_drop");
        applyStimulus(3'b111, 16, "s2_second32_lock2");
        applyStimulus(3'b000, 16, "s2_back16_drop");
        applyStimulus(3'b100, 16, "s2_relock3");

        applyStimulus(3'b001, 16, "s3_illegal_seqerr");
        applyStimulus(3'b111, 16, "s3_match1");
        applyStimulus(3'b000, 16, "s3_relock3");

        applyStimulus(3'b100, 20, "s4_pre20_stay");
        applyStimulus(3'b010, 16, "s4_dwell20_none");
        applyStimulus(3'b001, 16, "s4_match1_a");
        applyStimulus(3'b111, 16, "s4_relock_a");
        applyStimulus(3'b000, 13, "s4_pre13_stay");
        applyStimulus(3'b100, 16, "s4_dwell13_none");
        applyStimulus(3'b010, 16, "s4_match1_b");
        applyStimulus(3'b001, 16, "s4_relock_b");

        applyStimulus(3'b111, 16, "s5_stay_a");
        applyStimulus(3'b000, 16, "s5_stay_b");
        applyStimulus(3'b100, 200, "s5_hold");
        applyStimulus(3'b010, 8, "s5_clear_stall");

        #2 rst_n = 1'b0;
        #1;
        checkOutput("s6_async_speed", {30'd0, bus.SPEED}, 32'd0);
        checkOutput("s6_async_flags", {29'd0, bus.VALID, bus.SEQERR, bus.STALL}, 32'd0);
        bus.LED_IN = 3'b000;
        modelReset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        runScenario1("s6");

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blinkspeed_decoder.md
Name: blinkspeed_decoder

Overview:
Receive-side counterpart of the LED blink-speed sequencer. Observes the 3-bit RGB LED drive (5-step cycle 100→010→001→111→000→100), checks step order, measures per-step dwell time, and recovers the 2-bit speed code. Used as an on-board self-test or loopback checker beside the sequencer, fed either by the sequencer output or by an external pin.

Parameters:
BASE_LOG2, 24, log2 of the nominal step dwell in cycles at speed code 3; code k nominal N_k = 2^(BASE_LOG2+3-k).
TOL_SHIFT, 3, dwell tolerance = N_k >> TOL_SHIFT; must be ≥ 2 so code windows never overlap.
LOCK_CNT, 2, consecutive legal, same-code steps required to assert VALID; range 1..7.

Ports:
CLK  input  1  system clock; single clock domain.
RST  input  1  asynchronous, active-low reset.
LED_IN  input  3  observed RGB pattern; asynchronous to CLK.
SPEED  output  2  recovered speed code 0..3; 0 = slowest.
VALID  output  1  high while locked; SPEED meaningful only when high.
SEQERR  output  1  one-cycle pulse on an illegal pattern transition.
STALL  output  1  level; pattern unchanged beyond timeout.

Behaviour:
- Reset, async assert, RST low: SPEED=0, VALID=0, SEQERR=0, STALL=0, state=HUNT, dwell=0, match=0, sync and prev registers=3'b000. Outputs go to reset values immediately, with no clock edge required.
- Input path: 2-flop synchroniser (s1, s2), then prev register. change = (s2 != prev).
- Latency: all outputs are registered. They update on the 2nd rising edge after the edge that captures the new LED_IN into s1.
- Dwell counter, width BASE_LOG2+4:
  - Loads 1 on a change cycle; otherwise increments.
  - Saturates at all-ones.
  - On a change, the pre-load value is the dwell of the outgoing pattern.
- Legal transitions, only these: 100→010, 010→001, 001→111, 111→000, 000→100. Anything else is illegal, including any pattern outside the set.
- Classify(dwell): returns code k if |dwell − N_k| ≤ N_k>>TOL_SHIFT, otherwise "none".
- Timeout: TO = 2^(BASE_LOG2+3) + 2^(BASE_LOG2+2). When dwell == TO in any state:
  - STALL=1, VALID=0, match=0, state=HUNT.
- States:
  - HUNT:
    - Dwell so far is untrusted.
    - On change: clear STALL, go to MEASURE, match=0. Legality is not checked; the reset-value edge 000→x is ignored.
  - MEASURE (VALID=0), on change:
    - Illegal: SEQERR pulse, match=0.
    - Legal and "none": match=0.
    - Legal, code k, k==cand, match>0: match++.
    - Legal, code k, otherwise: cand=k, match=1.
    - When match reaches LOCK_CNT: go to LOCKED, SPEED=cand, VALID=1 (same edge).
  - LOCKED (VALID=1), on change:
    - Legal, same code: stay.
    - Legal, different code k: VALID=0, cand=k, match=1, go to MEASURE.
    - Legal, "none" (e.g. the partial step at a speed switch): VALID=0, match=0, go to MEASURE.
    - Illegal: SEQERR pulse, VALID=0, match=0, go to MEASURE.
- SPEED holds its last locked value while VALID=0. It changes only on entering LOCKED.
- Simultaneous change and timeout on the same edge: the change takes priority; timeout is evaluated only when there is no change.
- SEQERR is never asserted in HUNT or on the timeout edge.

Test Plan:
All scenarios use BASE_LOG2=4, TOL_SHIFT=3, LOCK_CNT=2 (N3=16 window 14..18, N2=32 window 28..36, N0=128, TO=192).
1. Release reset, drive the legal cycle with 16-cycle dwell -> HUNT→MEASURE on the first edge; VALID=1, SPEED=3 registered 2 edges after the 3rd pattern change; no SEQERR.
2. Locked at code 3, switch to 32-cycle dwell -> VALID falls at the first 32-dwell step end; VALID=1, SPEED=2 after the second; SPEED holds 3 in between.
3. Locked, drive 100→001 -> SEQERR high for exactly 1 cycle, VALID=0; relock to SPEED=3 after 2 further legal 16-cycle steps.
4. Locked at code 3, one step with dwell 20 (also repeated with dwell 13) -> VALID=0, SEQERR stays 0, relock after 2 good steps.
5. Hold 100 after lock -> STALL=1, VALID=0 when dwell reaches 192; next legal change clears STALL, state HUNT→MEASURE.
6. Pull RST low mid-MEASURE between clock edges -> all outputs 0 immediately; after release, scenario 1 repeats identically.
